vend_ctrl_gen2: RTL

VEND_CTRL_GEN2 -- requirements
Module: vend_ctrl_gen2

---
 rtl/vend_pkg.sv | 41 ++++
 rtl/vend_price_rom.sv | 20 ++
 rtl/vend_ctrl_gen2.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared definitions for the vending controller: state encoding, coin codes and the price table.
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SELECT   = 3'd1,
        ST_PAYMENT  = 3'd2,
        ST_DISPENSE = 3'd3,
        ST_CHANGE   = 3'd4
    } vend_state_t;

    localparam logic [2:0] COIN_1  = 3'd0;
    localparam logic [2:0] COIN_5  = 3'd1;
    localparam logic [2:0] COIN_10 = 3'd2;
    localparam logic [2:0] COIN_20 = 3'd3;
    localparam logic [2:0] COIN_50 = 3'd4;

    localparam logic [1:0] CHG_1  = 2'd0;
    localparam logic [1:0] CHG_5  = 2'd1;
    localparam logic [1:0] CHG_10 = 2'd2;

    // Indexed by {row-1, col-1}; rows and columns of the goods code run 1..4.
    localparam logic [3:0] PRICE_TAB [16] = '{
        4'd3,  4'd4, 4'd6,  4'd3,
        4'd10, 4'd8, 4'd9,  4'd7,
        4'd4,  4'd6, 4'd15, 4'd8,
        4'd9,  4'd4, 4'd5,  4'd5
    };

    function automatic logic [5:0] coin_amount(input logic [2:0] code);
        case (code)
            COIN_1:  return 6'd1;
            COIN_5:  return 6'd5;
            COIN_10: return 6'd10;
            COIN_20: return 6'd20;
            COIN_50: return 6'd50;
            default: return 6'd0;
        endcase
    endfunction

endpackage

// File: rtl/vend_price_rom.sv
// Combinational unit-price lookup: goods code {row, col} to price plus a valid flag.
module vend_price_rom
    import vend_pkg::*;
(
    input  logic [5:0] code,
    output logic [3:0] price,
    output logic       valid
);
    logic [2:0] row;
    logic [2:0] col;
    logic [1:0] r_idx;
    logic [1:0] c_idx;

    assign row   = code[5:3];
    assign col   = code[2:0];
    assign valid = (row >= 3'd1) && (row <= 3'd4) && (col >= 3'd1) && (col <= 3'd4);
    assign r_idx = 2'(row - 3'd1);
    assign c_idx = 2'(col - 3'd1);
    assign price = valid ? PRICE_TAB[{r_idx, c_idx}] : 4'd0;
endmodule

// File: rtl/vend_ctrl_gen2.sv
// Vending transaction controller: item selection, coin payment with timeout refund, vend and greedy change.
module vend_ctrl_gen2
    import vend_pkg::*;
#(
    parameter int MAX_ITEMS   = 4,
    parameter int MONEY_W     = 10,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               btn_start,
    input  logic               btn_add,
    input  logic               btn_confirm,
    input  logic               btn_cancel,
    input  logic [5:0]         goods_code,
    input  logic [1:0]         goods_qty,
    input  logic               coin_valid,
    input  logic [2:0]         coin_value,
    output logic [2:0]         state_out,
    output logic [3:0]         item_cnt,
    output logic [MONEY_W-1:0] need_money,
    output logic [MONEY_W-1:0] input_money,
    output logic [MONEY_W-1:0] change_money,
    output logic               vend_pulse,
    output logic               chg_coin_valid,
    output logic [1:0]         chg_coin_value,
    output logic               err_pulse
);
    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    if (MAX_ITEMS < 1 || MAX_ITEMS > 15) begin : g_bad_items
        $error("MAX_ITEMS must be within 1..15");
    end
    if (MONEY_W < $clog2(MAX_ITEMS * 45 + 1)) begin : g_bad_width
        $error("MONEY_W too narrow for the largest possible need_money");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYC must be at least 1");
    end

    vend_state_t        state;
    logic [TMR_W-1:0]   idle_cnt;
    logic [3:0]         unit_price;
    logic               price_ok;
    logic [5:0]         line_cost;
    logic               add_ok;
    logic [MONEY_W:0]   coin_sum;
    logic               coin_ok;
    logic [MONEY_W-1:0] next_input;
    logic               timed_out;

    vend_price_rom u_price_rom (
        .code  (goods_code),
        .price (unit_price),
        .valid (price_ok)
    );

    assign state_out  = state;
    assign line_cost  = 6'(unit_price) * 6'(goods_qty);
    assign add_ok     = price_ok && (goods_qty != 2'd0) && (item_cnt < 4'(MAX_ITEMS));
    // The extra top bit of coin_sum flags a coin that would overflow input_money.
    assign coin_sum   = {1'b0, input_money} + (MONEY_W + 1)'(coin_amount(coin_value));
    assign coin_ok    = coin_valid && (coin_value <= COIN_50) && !coin_sum[MONEY_W];
    assign next_input = coin_ok ? coin_sum[MONEY_W-1:0] : input_money;
    assign timed_out  = (idle_cnt == TMR_W'(TIMEOUT_CYC - 1)) && !coin_ok;

    // chg_coin_valid is a one-cycle strobe with no backpressure: the coin named by
    // chg_coin_value is released in every cycle the strobe is high.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state          <= ST_IDLE;
            idle_cnt       <= '0;
            item_cnt       <= '0;
            need_money     <= '0;
            input_money    <= '0;
            change_money   <= '0;
            vend_pulse     <= 1'b0;
            chg_coin_valid <= 1'b0;
            chg_coin_value <= '0;
            err_pulse      <= 1'b0;
        end else begin
            vend_pulse     <= 1'b0;
            chg_coin_valid <= 1'b0;
            err_pulse      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn_start) state <= ST_SELECT;
                end
                ST_SELECT: begin
                    if (btn_cancel) begin
                        state      <= ST_IDLE;
                        need_money <= '0;
                        item_cnt   <= '0;
                    end else if (btn_confirm) begin
                        if (item_cnt != 4'd0) begin
                            state    <= ST_PAYMENT;
                            idle_cnt <= '0;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end else if (btn_add) begin
                        if (add_ok) begin
                            need_money <= need_money + MONEY_W'(line_cost);
                            item_cnt   <= item_cnt + 4'd1;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end
                end
                ST_PAYMENT: begin
                    if (btn_cancel) begin
                        change_money <= input_money;
                        state        <= ST_CHANGE;
                    end else begin
                        if (coin_valid) begin
                            if (coin_ok) input_money <= coin_sum[MONEY_W-1:0];
                            else         err_pulse   <= 1'b1;
                        end
                        // Sufficiency is judged on the money held before this cycle's coin.
                        if (btn_confirm) begin
                            if (input_money >= need_money) begin
                                state        <= ST_DISPENSE;
                                vend_pulse   <= 1'b1;
                                change_money <= next_input - need_money;
                            end else begin
                                err_pulse <= 1'b1;
                            end
                        end else if (timed_out) begin
                            change_money <= next_input;
                            state        <= ST_CHANGE;
                        end
                        idle_cnt <= coin_ok ? '0 : idle_cnt + 1'b1;
                    end
                end
                ST_DISPENSE: begin
                    state <= ST_CHANGE;
                end
                ST_CHANGE: begin
                    if (change_money == '0) begin
                        state       <= ST_IDLE;
                        need_money  <= '0;
                        input_money <= '0;
                        item_cnt    <= '0;
                    end else if (change_money >= MONEY_W'(10)) begin
                        chg_coin_valid <= 1'b1;
                        chg_coin_value <= CHG_10;
                        change_money   <= change_money - MONEY_W'(10);
                    end else if (change_money >= MONEY_W'(5)) begin
                        chg_coin_valid <= 1'b1;
                        chg_coin_value <= CHG_5;
                        change_money   <= change_money - MONEY_W'(5);
                    end else begin
                        chg_coin_valid <= 1'b1;
                        chg_coin_value <= CHG_1;
                        change_money   <= change_money - MONEY_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
